blink_monitor: RTL

//  Downstream checker for the light/blink generator. Samples its single-bit

---
 rtl/blink_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/blink_monitor.sv
// Checker for a blink generator: measures the interval between light toggles,
// declares lock after LOCK_N in-tolerance intervals and latches a sticky fault.
module blink_monitor #(
    parameter int unsigned EXP_HALF = 25,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_N   = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TOG_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             light,
    input  logic             enable,
    input  logic             clear_err,
    output logic             edge_stb,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] half_period,
    output logic [TOG_W-1:0] toggles
);

    localparam int unsigned GOOD_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam logic [CNT_W:0]    MEAS_MIN = (CNT_W+1)'(EXP_HALF - TOL);
    localparam logic [CNT_W:0]    MEAS_MAX = (CNT_W+1)'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0]  CNT_TMO  = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_LST = GOOD_W'(LOCK_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRACK,
        S_LOCKED,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic               light_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic               edge_stb_q, edge_stb_d;
    logic               locked_q, locked_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   half_period_q, half_period_d;
    logic [TOG_W-1:0]   toggles_q, toggles_d;

    logic               edge_c;
    logic [CNT_W:0]     meas_c;
    logic               in_range_c;
    logic               timeout_c;

    assign edge_c     = (light != light_q);
    assign meas_c     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign in_range_c = (meas_c >= MEAS_MIN) && (meas_c <= MEAS_MAX);
    assign timeout_c  = !edge_c && (cnt_q == CNT_TMO);

    // Next-state, interval counter and statistics.
    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        half_period_d = half_period_q;
        toggles_d     = toggles_q;
        edge_stb_d    = edge_c;
        if (edge_c) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!enable) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            good_d    = '0;
            toggles_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ARM;
                    cnt_d     = '0;
                    good_d    = '0;
                    toggles_d = '0;
                end
                S_ARM: begin
                    if (edge_c) begin
                        toggles_d = toggles_q + TOG_W'(1);
                        state_d   = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (edge_c) begin
                        toggles_d     = toggles_q + TOG_W'(1);
                        half_period_d = meas_c[CNT_W-1:0];
                        if (!in_range_c) begin
                            good_d = '0;
                        end else if (good_q == GOOD_LST) begin
                            good_d  = '0;
                            state_d = S_LOCKED;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else if (timeout_c) begin
                        good_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (edge_c) begin
                        toggles_d     = toggles_q + TOG_W'(1);
                        half_period_d = meas_c[CNT_W-1:0];
                        if (!in_range_c) begin
                            state_d = S_FAULT;
                        end
                    end else if (timeout_c) begin
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (edge_c) begin
                        toggles_d     = toggles_q + TOG_W'(1);
                        half_period_d = meas_c[CNT_W-1:0];
                    end
                    // Clearing wins over the edge: the edge is counted but does not arm.
                    if (clear_err) begin
                        state_d = S_ARM;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
        fault_d  = (state_d == S_FAULT);
    end

    // State and output registers; light_q tracks light even in reset.
    always_ff @(posedge clk) begin
        light_q <= light;
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            good_q        <= '0;
            edge_stb_q    <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            half_period_q <= '0;
            toggles_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_q        <= good_d;
            edge_stb_q    <= edge_stb_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
            half_period_q <= half_period_d;
            toggles_q     <= toggles_d;
        end
    end

    assign edge_stb    = edge_stb_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign half_period = half_period_q;
    assign toggles     = toggles_q;

endmodule
